ldm_stm_sequencer: RTL and testbench

Multi-cycle sequencer for ARM load/store-multiple instructions. Sits between `inst_pattern_match` and the memory/register-file stage. Accepts one decoded LDM/STM command (base register, 16-bit register list, index/add/wback flags, base value) and emits one single-register transfer micro-op per set list bit, in ascending register order, followed by an optional base-writeback micro-op. Asserts `busy` so the decode stage stalls while the sequence runs.

---
 rtl/ldm_stm_sequencer_pkg.sv | 14 +
 rtl/ldm_stm_sequencer_if.sv | 29 ++
 rtl/ldm_stm_sequencer_lowest_set16.sv | 12 +
 rtl/ldm_stm_sequencer.sv | 102 ++++++++++
 tb/tb_ldm_stm_sequencer.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ldm_stm_sequencer_pkg.sv
// ldm_stm_sequencer_pkg: shared states, ARM register numbers and list helpers
package ldm_stm_sequencer_pkg;
  localparam int LIST_W = 16;
  localparam logic [3:0] REG_SP = 4'd13;
  localparam logic [3:0] REG_LR = 4'd14;
  localparam logic [3:0] REG_PC = 4'd15;
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, WB = 2'd2} state_t;
  function automatic logic [4:0] popcount16(input logic [LIST_W-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < LIST_W; i++) n = n + 5'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/ldm_stm_sequencer_if.sv
// ldm_stm_sequencer_if: command, micro-op and control signals of the sequencer
interface ldm_stm_sequencer_if #(parameter int AW = 32);
  import ldm_stm_sequencer_pkg::*;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_load;
  logic [3:0]        cmd_rn;
  logic [LIST_W-1:0] cmd_list;
  logic              cmd_index;
  logic              cmd_add;
  logic              cmd_wback;
  logic [AW-1:0]     cmd_base;
  logic              flush;
  logic              uop_valid;
  logic              uop_ready;
  logic              uop_wb;
  logic              uop_load;
  logic [3:0]        uop_reg;
  logic [AW-1:0]     uop_addr;
  logic              busy;
  modport master (
    output cmd_valid, cmd_load, cmd_rn, cmd_list, cmd_index, cmd_add, cmd_wback, cmd_base, flush, uop_ready,
    input  cmd_ready, uop_valid, uop_wb, uop_load, uop_reg, uop_addr, busy
  );
  modport slave (
    input  cmd_valid, cmd_load, cmd_rn, cmd_list, cmd_index, cmd_add, cmd_wback, cmd_base, flush, uop_ready,
    output cmd_ready, uop_valid, uop_wb, uop_load, uop_reg, uop_addr, busy
  );
endinterface

// File: rtl/ldm_stm_sequencer_lowest_set16.sv
// lowest_set16: priority encoder returning the index of the lowest set bit
module lowest_set16 (
  input  logic [15:0] i_vec,
  output logic [3:0]  o_idx,
  output logic        o_none
);
  always_comb begin
    o_idx = '0;
    for (int i = 15; i >= 0; i--) o_idx = i_vec[i] ? 4'(i) : o_idx;
  end
  assign o_none = ~|i_vec;
endmodule

// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: expands one LDM/STM into per-register transfers plus optional base writeback
module ldm_stm_sequencer #(parameter int AW = 32) (
  input logic                clk,
  input logic                rst_n,
  ldm_stm_sequencer_if.slave io
);
  import ldm_stm_sequencer_pkg::*;
  state_t            r_state;
  logic [LIST_W-1:0] r_remaining;
  logic [3:0]        r_rn;
  logic              r_wb_en;
  logic [AW-1:0]     r_wb_val;
  logic              r_uop_valid;
  logic              r_uop_wb;
  logic              r_uop_load;
  logic [3:0]        r_uop_reg;
  logic [AW-1:0]     r_uop_addr;
  logic [LIST_W-1:0] w_rest;
  logic [3:0]        w_cmd_idx;
  logic [3:0]        w_rest_idx;
  logic              w_cmd_none;
  logic              w_rest_none;
  logic [AW-1:0]     w_span;
  logic [AW-1:0]     w_first;
  logic [AW-1:0]     w_wb_val;
  logic              w_wb_en;
  logic              w_accept;
  logic              w_fire;
  lowest_set16 u_cmd_enc (.i_vec(io.cmd_list), .o_idx(w_cmd_idx), .o_none(w_cmd_none));
  lowest_set16 u_rest_enc (.i_vec(w_rest), .o_idx(w_rest_idx), .o_none(w_rest_none));
  // w_rest drops the bit of the uop currently on offer; empty means that uop is the last transfer
  assign w_rest   = r_remaining & (r_remaining - 16'd1);
  assign w_span   = AW'(popcount16(io.cmd_list)) << 2;
  assign w_first  = (io.cmd_add ? io.cmd_base : io.cmd_base - w_span) + ((io.cmd_index == io.cmd_add) ? AW'(4) : AW'(0));
  assign w_wb_val = io.cmd_add ? io.cmd_base + w_span : io.cmd_base - w_span;
  assign w_wb_en  = io.cmd_wback && !(io.cmd_load && io.cmd_list[io.cmd_rn]);
  assign w_accept = io.cmd_valid && (r_state == IDLE) && !io.flush;
  assign w_fire   = r_uop_valid && io.uop_ready;
  assign io.cmd_ready = r_state == IDLE;
  assign io.busy      = r_state != IDLE;
  assign io.uop_valid = r_uop_valid;
  assign io.uop_wb    = r_uop_wb;
  assign io.uop_load  = r_uop_load;
  assign io.uop_reg   = r_uop_reg;
  assign io.uop_addr  = r_uop_addr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_rn        <= '0;
      r_wb_en     <= 1'b0;
      r_wb_val    <= '0;
      r_uop_valid <= 1'b0;
      r_uop_wb    <= 1'b0;
      r_uop_load  <= 1'b0;
      r_uop_reg   <= '0;
      r_uop_addr  <= '0;
    end else if (io.flush) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_uop_valid <= 1'b0;
      r_uop_wb    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept && !w_cmd_none) begin
          r_state     <= XFER;
          r_remaining <= io.cmd_list;
          r_rn        <= io.cmd_rn;
          r_wb_en     <= w_wb_en;
          r_wb_val    <= w_wb_val;
          r_uop_valid <= 1'b1;
          r_uop_wb    <= 1'b0;
          r_uop_load  <= io.cmd_load;
          r_uop_reg   <= w_cmd_idx;
          r_uop_addr  <= w_first;
        end
        XFER: if (w_fire) begin
          r_remaining <= w_rest;
          if (!w_rest_none) begin
            r_uop_reg  <= w_rest_idx;
            r_uop_addr <= r_uop_addr + AW'(4);
          end else if (r_wb_en) begin
            r_state    <= WB;
            r_uop_wb   <= 1'b1;
            r_uop_load <= 1'b0;
            r_uop_reg  <= r_rn;
            r_uop_addr <= r_wb_val;
          end else begin
            r_state     <= IDLE;
            r_uop_valid <= 1'b0;
          end
        end
        WB: if (w_fire) begin
          r_state     <= IDLE;
          r_uop_valid <= 1'b0;
          r_uop_wb    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// tb_ldm_stm_sequencer: scoreboard bench for the LDM/STM micro-op sequencer
module tb_ldm_stm_sequencer;
  typedef struct packed {
    logic        wb;
    logic        ld;
    logic [3:0]  rg;
    logic [31:0] ad;
  } uop_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  uop_t q[$];
  uop_t m_got, m_exp;
  int n_cmp = 0;
  int n_bad = 0;
  ldm_stm_sequencer_if #(.AW(32)) bus ();
  ldm_stm_sequencer #(.AW(32)) dut (.clk(clk), .rst_n(rst_n), .io(bus));
  always #5 clk = ~clk;
  // scoreboard: every accepted uop is popped and compared against the expected stream
  always @(negedge clk) begin
    if (rst_n && bus.uop_valid && bus.uop_ready && !bus.flush) begin
      m_got = {bus.uop_wb, bus.uop_load, bus.uop_reg, bus.uop_addr};
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL uop_unexpected got wb=%b ld=%b reg=%0d addr=%h want none", m_got.wb, m_got.ld, m_got.rg, m_got.ad);
      end else begin
        m_exp = q.pop_front();
        if (m_got !== m_exp) begin
          n_bad++;
          $display("FAIL uop got wb=%b ld=%b reg=%0d addr=%h want wb=%b ld=%b reg=%0d addr=%h",
                   m_got.wb, m_got.ld, m_got.rg, m_got.ad, m_exp.wb, m_exp.ld, m_exp.rg, m_exp.ad);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic push(input logic wb, input logic ld, input logic [3:0] rg, input logic [31:0] ad);
    q.push_back({wb, ld, rg, ad});
  endtask
  task automatic issue(input logic ld, input logic [3:0] rn, input logic [15:0] list,
                       input logic idx, input logic add, input logic wbk, input logic [31:0] base);
    int g = 0;
    bus.cmd_load = ld;
    bus.cmd_rn = rn;
    bus.cmd_list = list;
    bus.cmd_index = idx;
    bus.cmd_add = add;
    bus.cmd_wback = wbk;
    bus.cmd_base = base;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL issue_ready got=%b want=1", bus.cmd_ready);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask
  task automatic wait_idle(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (q.size() == 0 && !bus.busy) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_reset;
    bus.cmd_valid = 0; bus.cmd_load = 0; bus.cmd_rn = 0; bus.cmd_list = 0; bus.cmd_index = 0;
    bus.cmd_add = 0; bus.cmd_wback = 0; bus.cmd_base = 0; bus.flush = 0; bus.uop_ready = 0;
    #12;
    n_cmp++;
    if ({bus.uop_valid, bus.uop_wb, bus.uop_load, bus.uop_reg, bus.uop_addr, bus.busy} !== 40'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got valid=%b wb=%b ld=%b reg=%0d addr=%h busy=%b want all 0",
               bus.uop_valid, bus.uop_wb, bus.uop_load, bus.uop_reg, bus.uop_addr, bus.busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.uop_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_cmd_ready got=%b want=1", bus.cmd_ready);
    end
  endtask
  task automatic test_ldmia_wb;
    int cnt = 0;
    bit ok;
    push(0, 1, 1, 32'h1000); push(0, 1, 3, 32'h1004); push(0, 1, 5, 32'h1008); push(1, 0, 0, 32'h100C);
    issue(1, 0, 16'h002A, 0, 1, 1, 32'h1000);
    while (bus.busy && cnt < 50) begin
      cnt++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (cnt != 4) begin
      n_bad++;
      $display("FAIL ldmia_busy_cycles got=%0d want=4", cnt);
    end
    wait_idle(50, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL ldmia_done got pending=%0d busy=%b want 0/0", q.size(), bus.busy);
    end
  endtask
  task automatic test_stmdb;
    bit ok;
    push(0, 0, 4, 32'h1FF8); push(0, 0, 14, 32'h1FFC); push(1, 0, 13, 32'h1FF8);
    issue(0, 13, 16'h4010, 1, 0, 1, 32'h2000);
    wait_idle(50, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL stmdb_done got pending=%0d busy=%b want 0/0", q.size(), bus.busy);
    end
  endtask
  task automatic test_da_ib;
    bit ok;
    push(0, 1, 0, 32'h0FC); push(0, 1, 15, 32'h100);
    issue(1, 1, 16'h8001, 0, 0, 0, 32'h100);
    push(0, 1, 0, 32'h104); push(0, 1, 15, 32'h108);
    issue(1, 1, 16'h8001, 1, 1, 0, 32'h100);
    wait_idle(50, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL da_ib_done got pending=%0d busy=%b want 0/0", q.size(), bus.busy);
    end
  endtask
  task automatic test_rn_in_list;
    bit ok;
    push(0, 1, 2, 32'h3000); push(0, 1, 7, 32'h3004);
    issue(1, 2, 16'h0084, 0, 1, 1, 32'h3000);
    push(0, 0, 2, 32'h3000); push(0, 0, 7, 32'h3004); push(1, 0, 2, 32'h3008);
    issue(0, 2, 16'h0084, 0, 1, 1, 32'h3000);
    wait_idle(50, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL rn_in_list_done got pending=%0d busy=%b want 0/0", q.size(), bus.busy);
    end
  endtask
  task automatic test_stall;
    bit ok;
    push(0, 1, 1, 32'h40); push(0, 1, 2, 32'h44); push(0, 1, 3, 32'h48);
    issue(1, 0, 16'h000E, 0, 1, 0, 32'h40);
    @(posedge clk); #1;
    bus.uop_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.uop_valid, bus.uop_reg, bus.uop_addr} !== {1'b1, 4'd2, 32'h44}) begin
        n_bad++;
        $display("FAIL stall_hold cycle=%0d got valid=%b reg=%0d addr=%h want 1/2/00000044",
                 i, bus.uop_valid, bus.uop_reg, bus.uop_addr);
      end
    end
    bus.uop_ready = 1'b1;
    wait_idle(50, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL stall_done got pending=%0d busy=%b want 0/0", q.size(), bus.busy);
    end
  endtask
  task automatic test_empty;
    int bad = 0;
    issue(1, 0, 16'h0000, 0, 1, 1, 32'h700);
    for (int i = 0; i < 5; i++) begin
      if (!bus.cmd_ready || bus.uop_valid || bus.busy) bad++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL empty_list got bad_cycles=%0d want 0", bad);
    end
  endtask
  task automatic test_flush;
    bit ok;
    push(0, 1, 1, 32'h500);
    issue(1, 0, 16'h001E, 0, 1, 1, 32'h500);
    @(posedge clk); #1;
    bus.flush = 1'b1;
    bus.uop_ready = 1'b0;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    n_cmp++;
    if ({bus.uop_valid, bus.busy, bus.cmd_ready} !== 3'b001) begin
      n_bad++;
      $display("FAIL flush_idle got valid=%b busy=%b ready=%b want 0/0/1", bus.uop_valid, bus.busy, bus.cmd_ready);
    end
    bus.uop_ready = 1'b1;
    bus.cmd_list = 16'h0003;
    bus.cmd_valid = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.flush = 1'b0;
    n_cmp++;
    if ({bus.uop_valid, bus.busy, q.size() == 0} !== 3'b001) begin
      n_bad++;
      $display("FAIL flush_cmd_dropped got valid=%b busy=%b pending=%0d want 0/0/0", bus.uop_valid, bus.busy, q.size());
    end
    push(0, 0, 0, 32'h10);
    issue(0, 5, 16'h0001, 0, 1, 0, 32'h10);
    wait_idle(50, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL flush_recover got pending=%0d busy=%b want 0/0", q.size(), bus.busy);
    end
  endtask
  task automatic test_async_reset;
    bit ok;
    push(0, 1, 1, 32'h600);
    issue(1, 0, 16'h001E, 0, 1, 1, 32'h600);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.uop_valid, bus.uop_wb, bus.uop_load, bus.uop_reg, bus.uop_addr, bus.busy} !== 40'd0) begin
      n_bad++;
      $display("FAIL async_reset got valid=%b wb=%b ld=%b reg=%0d addr=%h busy=%b want all 0",
               bus.uop_valid, bus.uop_wb, bus.uop_load, bus.uop_reg, bus.uop_addr, bus.busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_cmp++;
    if ({bus.cmd_ready, q.size() == 0} !== 2'b11) begin
      n_bad++;
      $display("FAIL async_reset_release got ready=%b pending=%0d want 1/0", bus.cmd_ready, q.size());
    end
    push(0, 1, 1, 32'h1000); push(0, 1, 3, 32'h1004); push(0, 1, 5, 32'h1008); push(1, 0, 0, 32'h100C);
    issue(1, 0, 16'h002A, 0, 1, 1, 32'h1000);
    wait_idle(50, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL async_reset_recover got pending=%0d busy=%b want 0/0", q.size(), bus.busy);
    end
  endtask
  task automatic test_back_to_back;
    bit ok;
    push(0, 0, 13, 32'h8000); push(0, 0, 14, 32'h8004); push(0, 0, 15, 32'h8008); push(1, 0, 1, 32'h800C);
    issue(0, 1, 16'hE000, 0, 1, 1, 32'h8000);
    n_cmp++;
    if (bus.cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_ready_low got=%b want=0", bus.cmd_ready);
    end
    push(0, 1, 0, 32'hFFFFFFF8); push(0, 1, 4, 32'hFFFFFFFC); push(1, 0, 3, 32'hFFFFFFF8);
    issue(1, 3, 16'h0011, 1, 0, 1, 32'h0);
    wait_idle(60, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL b2b_done got pending=%0d busy=%b want 0/0", q.size(), bus.busy);
    end
  endtask
  initial begin
    test_reset;
    test_ldmia_wb;
    test_stmdb;
    test_da_ib;
    test_rn_in_list;
    test_stall;
    test_empty;
    test_flush;
    test_async_reset;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
